alu_pc_unit: RTL and testbench

- Execute-stage core of the 16-bit RISC datapath.
- Contains a combinational 16-bit ALU (AND/ADD/OR/SUB/SLT/NOR, with signed overflow and zero flags) and a program-counter register with next-PC selection (sequential, branch-relative, absolute jump, hold).
- Sits between the register file, which supplies operands, and the instruction memory, which is addressed by pc.
- Clock is supplied externally; no clock generation inside the block.

---
 rtl/alu_pc_pkg.sv | 26 ++
 rtl/alu_pc_unit_alu16.sv | 72 +++++++
 rtl/alu_pc_unit.sv | 65 ++++++
 tb/tb_alu_pc_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pc_pkg.sv
// Shared constants for the execute-stage ALU and program-counter unit.
// ALU operation codes and next-PC select codes are defined here.
// The extended ALU codes (XOR/SLL/SRL) are only decoded by alu16
// when ALU_EXT_EN is defined.
package alu_pc_pkg;

  localparam int DATA_W = 16;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;

  // Next-PC select codes
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

endpackage

// File: rtl/alu_pc_unit_alu16.sv
// Combinational 16-bit ALU: AND/ADD/OR/SUB/SLT/NOR with signed overflow
// and zero flags. Defining ALU_EXT_EN adds XOR, logical shift left and
// logical shift right; without it those codes yield 0 like any other
// undecoded operation.
module alu16
  import alu_pc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              zero
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] sum_s;
  logic signed [DATA_W-1:0] diff_s;

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] s);
    return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
  endfunction

  // Signed overflow of a - b: operand signs differ and result sign left a's.
  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] d);
    return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
  endfunction

  assign a_s    = a;
  assign b_s    = b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // Operation decode; SLT uses a direct signed compare so it stays correct
  // when a - b would overflow.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_ADD: begin
        result   = sum_s;
        overflow = add_ovf(a_s, b_s, sum_s);
      end
      ALU_OR:  result = a | b;
      ALU_SUB: begin
        result   = diff_s;
        overflow = sub_ovf(a_s, b_s, diff_s);
      end
      ALU_SLT: result = (a_s < b_s) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      ALU_NOR: result = ~(a | b);
`ifdef ALU_EXT_EN
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
`endif
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pc_unit.sv
// Execute-stage core: combinational ALU (alu16) plus the program-counter
// register and its next-PC mux (sequential, branch-relative, absolute
// jump, hold). Only pc is registered. Optional macro ALU_EXT_EN enables
// the extended ALU operations inside alu16.
module alu_pc_unit
  import alu_pc_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          PC_STEP  = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_a,
  input  logic [15:0] alu_b,
  input  logic [3:0]  alu_ctrl,
  output logic [15:0] alu_result,
  output logic        alu_overflow,
  output logic        alu_zero,
  input  logic        pc_en,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] jump_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_next
);

  localparam logic [15:0] STEP = 16'(PC_STEP);

  logic [15:0] seq_pc;
  logic [15:0] br_pc;

  alu16 u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .ctrl     (alu_ctrl),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // Branch offset is a word count, so it is scaled to bytes; sums wrap.
  assign seq_pc = pc + STEP;
  assign br_pc  = seq_pc + {jump_addr[13:0], 2'b00};

  // Next-PC selection; a not-taken branch falls through sequentially.
  always_comb begin
    pc_next = seq_pc;
    case (pc_sel)
      PC_SEQ:  pc_next = seq_pc;
      PC_BR:   pc_next = alu_zero ? br_pc : seq_pc;
      PC_JMP:  pc_next = {jump_addr[15:2], 2'b00};
      PC_HOLD: pc_next = pc;
      default: pc_next = seq_pc;
    endcase
  end

  // PC register; reset takes priority over enable and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (pc_en) begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_alu_pc_unit.sv
// Self-checking bench for alu_pc_unit: an arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_alu_pc_unit;
  import alu_pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        alu_overflow, alu_zero;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [15:0] jump_addr;
  logic [15:0] pc, pc_next;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  alu_pc_unit dut (
    .clk(clk), .rst(rst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .pc_en(pc_en), .pc_sel(pc_sel), .jump_addr(jump_addr),
    .pc(pc), .pc_next(pc_next)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference ALU using integer arithmetic on signed/unsigned values.
  function automatic void alu_model(input logic [3:0] c, input logic [15:0] a,
                                    input logic [15:0] b,
                                    output logic [15:0] r, output logic o);
    int sa, sb, s;
    int unsigned ua, sh;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    sh = b % 16;
    r = 16'h0000;
    o = 1'b0;
    case (c)
      4'd0: r = a & b;
      4'd1: begin s = sa + sb; r = s[15:0]; o = (s > 32767) || (s < -32768); end
      4'd2: r = a | b;
      4'd5: begin s = sa - sb; r = s[15:0]; o = (s > 32767) || (s < -32768); end
      4'd7: r = (sa < sb) ? 16'h0001 : 16'h0000;
      4'd8: r = ~(a | b);
`ifdef ALU_EXT_EN
      4'd3: r = a ^ b;
      4'd4: begin ua = (ua * (2 ** sh)) % 65536; r = ua[15:0]; end
      4'd6: begin ua = ua / (2 ** sh); r = ua[15:0]; end
`endif
      default: begin r = 16'h0000; o = 1'b0; end
    endcase
  endfunction

  function automatic logic [15:0] pc_model(input logic [15:0] p, input logic [1:0] sel,
                                           input logic [15:0] j, input logic z);
    int unsigned v;
    int unsigned pi, ji;
    pi = p;
    ji = j;
    case (sel)
      2'd0: v = (pi + 4) % 65536;
      2'd1: v = z ? (pi + 4 + ji * 4) % 65536 : (pi + 4) % 65536;
      2'd2: v = ji - (ji % 4);
      default: v = pi;
    endcase
    return v[15:0];
  endfunction

  // Model PC state, advanced on each rising edge from the same inputs.
  always @(posedge clk) begin
    logic [15:0] r;
    logic o;
    alu_model(alu_ctrl, alu_a, alu_b, r, o);
    if (rst) begin
      exp_pc = 16'h0000;
      model_on = 1'b1;
    end else if (model_on && pc_en) begin
      exp_pc = pc_model(exp_pc, pc_sel, jump_addr, r == 16'h0000);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] r;
    logic o;
    alu_model(alu_ctrl, alu_a, alu_b, r, o);
    chk("m_result", alu_result, r);
    chk("m_overflow", {15'd0, alu_overflow}, {15'd0, o});
    chk("m_zero", {15'd0, alu_zero}, {15'd0, r == 16'h0000});
    if (model_on) begin
      chk("m_pc", pc, exp_pc);
      chk("m_pc_next", pc_next, pc_model(exp_pc, pc_sel, jump_addr, r == 16'h0000));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_chk(input string name, input logic [3:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic eo,
                         input logic ez);
    alu_ctrl = c;
    alu_a = a;
    alu_b = b;
    #1;
    chk({name, "_res"}, alu_result, er);
    chk({name, "_ovf"}, {15'd0, alu_overflow}, {15'd0, eo});
    chk({name, "_zero"}, {15'd0, alu_zero}, {15'd0, ez});
  endtask

  initial begin
    rst = 1'b1; pc_en = 1'b1; pc_sel = PC_JMP; jump_addr = 16'h1234;
    alu_a = 16'h0000; alu_b = 16'h0000; alu_ctrl = ALU_AND;
    tick();
    tick();
    chk("reset_pc", pc, 16'h0000);

    rst = 1'b0; pc_sel = PC_SEQ;
    tick(); chk("seq_1", pc, 16'h0004);
    tick(); chk("seq_2", pc, 16'h0008);
    tick(); chk("seq_3", pc, 16'h000C);

    pc_en = 1'b0;
    alu_chk("and", ALU_AND, 16'h00F0, 16'h0F0F, 16'h0000, 1'b0, 1'b1);
    alu_chk("or",  ALU_OR,  16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0);
    alu_chk("nor", ALU_NOR, 16'h00F0, 16'h0F0F, 16'hF000, 1'b0, 1'b0);
    alu_chk("add", ALU_ADD, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0);
    alu_chk("add_ovf", ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
    alu_chk("sub_ovf", ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    alu_chk("sub_eq",  ALU_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1);
    alu_chk("add_neg", ALU_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    alu_chk("slt_lt",  ALU_SLT, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    alu_chk("slt_gt",  ALU_SLT, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b1);
    alu_chk("slt_eq",  ALU_SLT, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
    alu_chk("undef",   4'b1111, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
`ifdef ALU_EXT_EN
    alu_chk("sll",  ALU_SLL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0);
    alu_chk("srl",  ALU_SRL, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0);
    alu_chk("xor",  ALU_XOR, 16'h00F0, 16'h0FF0, 16'h0F00, 1'b0, 1'b0);
`else
    alu_chk("sll_off", ALU_SLL, 16'h0001, 16'h000F, 16'h0000, 1'b0, 1'b1);
    alu_chk("xor_off", ALU_XOR, 16'h00F0, 16'h0FF0, 16'h0000, 1'b0, 1'b1);
`endif

    pc_en = 1'b1; pc_sel = PC_JMP; jump_addr = 16'h0010;
    tick(); chk("jmp_0010", pc, 16'h0010);
    pc_sel = PC_BR; jump_addr = 16'h0003;
    alu_ctrl = ALU_SUB; alu_a = 16'h0005; alu_b = 16'h0005;
    #1 chk("br_next", pc_next, 16'h0020);
    tick(); chk("br_taken", pc, 16'h0020);
    pc_sel = PC_JMP; jump_addr = 16'h0010;
    tick();
    pc_sel = PC_BR; jump_addr = 16'h0003; alu_b = 16'h0004;
    tick(); chk("br_not_taken", pc, 16'h0014);
    pc_sel = PC_JMP; jump_addr = 16'h00A7;
    tick(); chk("jmp_align", pc, 16'h00A4);

    pc_en = 1'b0; pc_sel = PC_SEQ;
    for (int i = 0; i < 3; i++) begin tick(); chk("hold_en", pc, 16'h00A4); end
    pc_en = 1'b1; pc_sel = PC_HOLD;
    for (int i = 0; i < 3; i++) begin tick(); chk("hold_sel", pc, 16'h00A4); end

    pc_sel = PC_JMP; jump_addr = 16'hFFFC;
    tick(); chk("jmp_fffc", pc, 16'hFFFC);
    pc_sel = PC_SEQ;
    tick(); chk("wrap", pc, 16'h0000);

    pc_sel = PC_JMP; jump_addr = 16'h0400;
    tick();
    rst = 1'b1;
    tick(); chk("reset_mid", pc, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      alu_a = 16'($urandom);
      alu_b = (i % 4 == 0) ? alu_a : 16'($urandom);
      alu_ctrl = 4'($urandom_range(0, 15));
      pc_en = ($urandom_range(0, 3) != 0);
      pc_sel = 2'($urandom_range(0, 3));
      jump_addr = 16'($urandom);
      tick();
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
